// File: rtl/byte_rx_pkg.sv
// Shared types and constants for the byte_rx serial receiver.
package byte_rx_pkg;

   localparam int RX_DATA_BITS = 8;
   localparam logic [RX_DATA_BITS-1:0] RX_DATA_RST = 8'h00;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

endpackage

// File: rtl/byte_rx_if.sv
// Serial line plus received-byte bus of byte_rx; master is the receiver, slave the consumer.
interface byte_rx_if;
   import byte_rx_pkg::*;

   logic                    rxd;
   logic [RX_DATA_BITS-1:0] data;
   logic                    en;
   logic                    busy;
   logic                    frame_err;
   logic                    parity_err;

   modport master (
      input  rxd,
      output data, en, busy, frame_err, parity_err
   );

   modport slave (
      output rxd,
      input  data, en, busy, frame_err, parity_err
   );

endinterface

// File: rtl/byte_rx_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/byte_rx.sv
// Oversampling 8N1 serial byte receiver; define BYTE_RX_PARITY_EN to add an even-parity bit (8E1).
module byte_rx
   import byte_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   byte_rx_if.master bus
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   rx_state_t               state;
   rx_state_t               state_nxt;
   logic [CW-1:0]           cnt;
   logic [2:0]              idx;
   logic                    armed;
   logic [RX_DATA_BITS-1:0] shreg;
   logic [RX_DATA_BITS-1:0] data_r;
   logic                    rxd_s;
   logic                    sample;
   logic                    stop_tick;
   logic                    busy_c;
   logic                    en_nxt;
   logic                    ferr_nxt;
   logic                    en_r;
   logic                    ferr_r;

`ifdef BYTE_RX_PARITY_EN
   logic                    par_bit;
   logic                    perr_nxt;
   logic                    perr_r;
`endif

   sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.rxd),
      .q     (rxd_s)
   );

   // START waits half a bit to land mid-bit; later states sample once per full bit.
   always_comb begin
      sample = 1'b0;
      case (state)
         IDLE:    sample = 1'b0;
         START:   sample = (cnt == HALF);
         default: sample = (cnt == LAST);
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (!rxd_s && armed) state_nxt = START;
         START:  if (sample) state_nxt = rxd_s ? IDLE : DATA;
`ifdef BYTE_RX_PARITY_EN
         DATA:   if (sample && idx == 3'd7) state_nxt = PARITY;
         PARITY: if (sample) state_nxt = STOP;
`else
         DATA:   if (sample && idx == 3'd7) state_nxt = STOP;
`endif
         STOP:   if (sample) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_c    = (state != IDLE);
      stop_tick = (state == STOP) && sample;
      ferr_nxt  = stop_tick && !rxd_s;
`ifdef BYTE_RX_PARITY_EN
      perr_nxt  = stop_tick && (^{shreg, par_bit});
      en_nxt    = stop_tick && rxd_s && !(^{shreg, par_bit});
`else
      en_nxt    = stop_tick && rxd_s;
`endif
   end

   // armed only follows the line in IDLE, so a low line after a bad stop bit cannot restart a frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt    <= '0;
         idx    <= '0;
         armed  <= 1'b0;
         data_r <= RX_DATA_RST;
         en_r   <= 1'b0;
         ferr_r <= 1'b0;
      end else begin
         cnt <= (state == IDLE || sample) ? '0 : cnt + 1'b1;
         if (state != DATA) idx <= '0;
         else if (sample)   idx <= idx + 3'd1;
         if (state == IDLE)                    armed <= rxd_s;
         else if (stop_tick && rxd_s)          armed <= 1'b1;
         en_r   <= en_nxt;
         ferr_r <= ferr_nxt;
         if (en_nxt) data_r <= shreg;
      end
   end

   always_ff @(posedge clk) begin
      if (state == DATA && sample) shreg[idx] <= rxd_s;
   end

`ifdef BYTE_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (state == PARITY && sample) par_bit <= rxd_s;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) perr_r <= 1'b0;
      else        perr_r <= perr_nxt;
   end

   assign bus.parity_err = perr_r;
`else
   assign bus.parity_err = 1'b0;
`endif

   assign bus.data      = data_r;
   assign bus.en        = en_r;
   assign bus.busy      = busy_c;
   assign bus.frame_err = ferr_r;

endmodule

// File: tb/tb_byte_rx.sv
// Directed bench for byte_rx: latency, glitch rejection, framing/parity errors, back-to-back frames, mid-frame reset.
module tb_byte_rx;
   import byte_rx_pkg::*;

   localparam int C = 16;
`ifdef BYTE_RX_PARITY_EN
   localparam int LAT   = 171;
   localparam int FRAME = 11 * C;
`else
   localparam int LAT   = 155;
   localparam int FRAME = 10 * C;
`endif

   logic clk = 1'b0;
   logic rst_n;
   byte_rx_if bus ();

   byte_rx #(.CLKS_PER_BIT(C)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   int t0 = 0;

   // Event recorder, sampled on the falling edge.
   int         en_cnt = 0, en_cyc = 0, prev_en_cyc = 0;
   int         ferr_cnt = 0, ferr_cyc = 0, perr_cnt = 0, perr_cyc = 0;
   int         busy_rise = -1, busy_fall = -1;
   logic [7:0] en_data = 8'h00, prev_en_data = 8'h00;
   logic       busy_q = 1'b0;

   always @(negedge clk) begin
      if (bus.en === 1'b1) begin
         en_cnt++;
         prev_en_cyc  = en_cyc;
         prev_en_data = en_data;
         en_cyc       = cyc;
         en_data      = bus.data;
      end
      if (bus.frame_err === 1'b1) begin
         ferr_cnt++;
         ferr_cyc = cyc;
      end
      if (bus.parity_err === 1'b1) begin
         perr_cnt++;
         perr_cyc = cyc;
      end
      if (bus.busy === 1'b1 && !busy_q) busy_rise = cyc;
      if (bus.busy === 1'b0 && busy_q)  busy_fall = cyc;
      busy_q = (bus.busy === 1'b1);
   end

`ifdef BYTE_RX_PARITY_EN
   logic par_flip = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called #1 after a rising edge; leaves the stop level on the line.
   task automatic send(input logic [7:0] b, input logic stop);
      bus.rxd = 1'b0;
      t0 = cyc;
      repeat (C) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         bus.rxd = b[i];
         repeat (C) @(posedge clk);
         #1;
      end
`ifdef BYTE_RX_PARITY_EN
      bus.rxd = (^b) ^ par_flip;
      repeat (C) @(posedge clk);
      #1;
`endif
      bus.rxd = stop;
      repeat (C) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.rxd = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   int n0, f0, p0;

   initial begin
      bus.rxd = 1'b1;
      rst_n   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_data", 32'(bus.data), 32'(RX_DATA_RST));
      chk("rst_en", 32'(bus.en), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_ferr", 32'(bus.frame_err), 32'd0);
      chk("rst_perr", 32'(bus.parity_err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(2 * C);

      // Single good byte
      n0 = en_cnt;
      send(8'hA5, 1'b1);
      idle(4);
      @(negedge clk);
      chk("a5_en_count", 32'(en_cnt), 32'(n0 + 1));
      chk("a5_en_cycle", 32'(en_cyc), 32'(t0 + LAT));
      chk("a5_data", 32'(en_data), 32'h0000_00A5);
      chk("a5_ferr", 32'(ferr_cnt), 32'd0);
      chk("a5_busy_rise", 32'(busy_rise), 32'(t0 + 3));
      chk("a5_busy_fall", 32'(busy_fall), 32'(t0 + LAT));
      chk("a5_busy_after", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;

      // Three-cycle glitch is rejected, then 8'h0F arrives
      n0 = en_cnt;
      f0 = ferr_cnt;
      bus.rxd = 1'b0;
      t0 = cyc;
      repeat (3) @(posedge clk);
      #1;
      idle(40);
      @(negedge clk);
      chk("glitch_en", 32'(en_cnt), 32'(n0));
      chk("glitch_ferr", 32'(ferr_cnt), 32'(f0));
      chk("glitch_busy_rise", 32'(busy_rise), 32'(t0 + 3));
      chk("glitch_busy_fall", 32'(busy_fall), 32'(t0 + C / 2 + 3));
      @(posedge clk);
      #1;
      send(8'h0F, 1'b1);
      idle(4);
      @(negedge clk);
      chk("post_glitch_en", 32'(en_cnt), 32'(n0 + 1));
      chk("post_glitch_data", 32'(en_data), 32'h0000_000F);
      chk("post_glitch_cycle", 32'(en_cyc), 32'(t0 + LAT));
      @(posedge clk);
      #1;

      // Framing error: stop bit low
      n0 = en_cnt;
      f0 = ferr_cnt;
      send(8'h3C, 1'b0);
      idle(C);
      @(negedge clk);
      chk("ferr_count", 32'(ferr_cnt), 32'(f0 + 1));
      chk("ferr_cycle", 32'(ferr_cyc), 32'(t0 + LAT));
      chk("ferr_no_en", 32'(en_cnt), 32'(n0));
      chk("ferr_data_held", 32'(bus.data), 32'h0000_000F);
      @(posedge clk);
      #1;
      send(8'h81, 1'b1);
      idle(4);
      @(negedge clk);
      chk("after_ferr_en", 32'(en_cnt), 32'(n0 + 1));
      chk("after_ferr_data", 32'(en_data), 32'h0000_0081);
      @(posedge clk);
      #1;

      // Back-to-back frames
      n0 = en_cnt;
      send(8'h0F, 1'b1);
      send(8'hF0, 1'b1);
      idle(4);
      @(negedge clk);
      chk("b2b_count", 32'(en_cnt), 32'(n0 + 2));
      chk("b2b_spacing", 32'(en_cyc - prev_en_cyc), 32'(FRAME));
      chk("b2b_first", 32'(prev_en_data), 32'h0000_000F);
      chk("b2b_second", 32'(en_data), 32'h0000_00F0);
      chk("b2b_cycle", 32'(en_cyc), 32'(t0 + LAT));
      @(posedge clk);
      #1;

      // Reset pulse in the middle of data bit 4
      n0 = en_cnt;
      bus.rxd = 1'b0;
      repeat (C) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         bus.rxd = i[0];
         repeat (C) @(posedge clk);
         #1;
      end
      bus.rxd = 1'b0;
      repeat (C / 2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_data", 32'(bus.data), 32'(RX_DATA_RST));
      chk("mid_rst_en", 32'(bus.en), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_ferr", 32'(bus.frame_err), 32'd0);
      chk("mid_rst_perr", 32'(bus.parity_err), 32'd0);
      @(posedge clk);
      #1;
      idle(3 * C);
      @(negedge clk);
      chk("aborted_no_en", 32'(en_cnt), 32'(n0));
      @(posedge clk);
      #1;
      send(8'h55, 1'b1);
      idle(4);
      @(negedge clk);
      chk("after_rst_en", 32'(en_cnt), 32'(n0 + 1));
      chk("after_rst_data", 32'(en_data), 32'h0000_0055);
      chk("after_rst_cycle", 32'(en_cyc), 32'(t0 + LAT));
      @(posedge clk);
      #1;

`ifdef BYTE_RX_PARITY_EN
      // Wrong parity bit
      n0 = en_cnt;
      f0 = ferr_cnt;
      p0 = perr_cnt;
      par_flip = 1'b1;
      send(8'h03, 1'b1);
      par_flip = 1'b0;
      idle(4);
      @(negedge clk);
      chk("perr_count", 32'(perr_cnt), 32'(p0 + 1));
      chk("perr_cycle", 32'(perr_cyc), 32'(t0 + LAT));
      chk("perr_no_en", 32'(en_cnt), 32'(n0));
      chk("perr_no_ferr", 32'(ferr_cnt), 32'(f0));
      @(posedge clk);
      #1;
      send(8'h03, 1'b1);
      idle(4);
      @(negedge clk);
      chk("par_ok_en", 32'(en_cnt), 32'(n0 + 1));
      chk("par_ok_cycle", 32'(en_cyc), 32'(t0 + 171));
      chk("par_ok_data", 32'(en_data), 32'h0000_0003);
`else
      p0 = perr_cnt;
      chk("perr_never", 32'(p0), 32'd0);
      chk("perr_tied", 32'(bus.parity_err), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/byte_rx.md
# byte_rx

Serial byte receiver that sits directly upstream of the control FSM and feeds its `data`/`en` inputs. It oversamples an asynchronous 8N1 serial line, reassembles each frame into a byte, and presents it on `data` together with a one-cycle `en` strobe. Malformed frames are flagged and never strobed downstream.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; integer, minimum 4, even values only.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, **synchronous, active-low**.
- `rxd` in 1: asynchronous serial line, idle high.
- `data` out 8: last good byte, LSB received first. Holds its value until the next good byte.
- `en` out 1: one-cycle strobe, high in the cycle `data` is updated.
- `busy` out 1: high from start-bit detection to return to IDLE.
- `frame_err` out 1: one-cycle pulse when the stop bit samples low.
- `parity_err` out 1: one-cycle pulse on parity mismatch. Tied 0 when parity is compiled out.

## Operation
- `rxd` passes through a 2-flop synchronizer, giving `rxd_s`. All decisions use `rxd_s`.
- Bit counter `cnt` is `$clog2(CLKS_PER_BIT)` bits wide. Bit index `idx` is 3 bits.
- **IDLE**
  - An `armed` flag sets whenever `rxd_s`=1.
  - `rxd_s`=0 with `armed` → START. This clears `cnt`, sets `busy`, and clears `armed`.
- **START**
  - After `CLKS_PER_BIT/2` cycles, resample `rxd_s`.
  - Sample 0 → DATA.
  - Sample 1 → IDLE. This is a glitch: no flag, `busy` drops.
- **DATA**
  - Every `CLKS_PER_BIT` cycles, sample `rxd_s` into shift register bit `idx`, LSB first.
  - After `idx`=7 → PARITY if compiled in, else STOP.
- **PARITY** (optional)
  - One bit period later, sample the parity bit.
  - Even parity: the XOR of the 8 data bits and the parity bit must be 0.
- **STOP**
  - One bit period later, sample `rxd_s`.
  - Sample 1 with no parity error: load `data`, pulse `en`.
  - Sample 0: pulse `frame_err`; `data` is unchanged, no `en`.
  - Parity error with stop bit 1: pulse `parity_err`; no `en`.
  - Both errors: pulse both flags.
  - All cases → IDLE.
- After a frame error, the receiver does not re-arm until the line has been seen high (break handling).
- `busy` is high in START, DATA, PARITY and STOP.
- Reset (`rst_n`=0 at a clock edge), including mid-frame:
  - State → IDLE; `armed` → 0; counters clear; synchronizer flops → 1.
  - `data`=8'h00, `en`=0, `busy`=0, `frame_err`=0, `parity_err`=0.
  - A partial frame is discarded. A frame already in progress when reset releases is ignored until the line is seen idle high.

## Timing
- `en`, `frame_err` and `parity_err` are registered. Each is high for exactly one cycle per frame.
- Let t0 be the first cycle `rxd` is low. `en` is high at t0 + 9.5·`CLKS_PER_BIT` + 3.
  - This is 155 cycles at the default.
  - Add `CLKS_PER_BIT` cycles when parity is compiled in.
- `data` changes in the same cycle `en` rises.
- Back-to-back frames: a start bit that immediately follows a good stop bit is detected. The minimum frame spacing is 10 bit periods, or 11 with parity.
- `busy` rises 3 cycles after t0 and falls in the cycle after the stop sample.

## Configuration
- `BYTE_RX_PARITY_EN` defined:
  - The PARITY state exists and even parity is checked.
  - Frames are 11 bits: start, 8 data, parity, stop.
- `BYTE_RX_PARITY_EN` undefined:
  - The PARITY state and its logic are removed.
  - Frames are 10 bits (8N1).
  - `parity_err` is a constant 0.
- The port list is identical in both builds.

## Structure
- Package `byte_rx_pkg`:
  - State enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP).
  - `RX_DATA_BITS`=8.
  - Reset constant for `data`, `RX_DATA_RST`=8'h00.
- Sub-module `sync2`: a 2-flop synchronizer with a reset value parameter, instantiated once for `rxd` with reset value 1.

## Test plan
- Default build, `CLKS_PER_BIT`=16, send 8'hA5 → a single `en` pulse at t0+155 with `data`=8'hA5; `frame_err`=0; `busy` low afterwards.
- Drive `rxd` low for 3 cycles from idle → no `en` and no flags; `busy` pulses briefly, then the next valid byte 8'h0F is received correctly.
- Send 8'h3C with the stop bit driven low → `frame_err` pulse at the stop sample; no `en`; `data` retains its previous value; the next frame sent after ≥1 bit of idle high yields 8'h81.
- Send 8'h0F then 8'hF0 back-to-back with no idle gap → two `en` pulses exactly 160 cycles apart, carrying 8'h0F and 8'hF0.
- Assert `rst_n`=0 for 1 cycle in the middle of data bit 4 → next cycle all outputs are at reset values; no `en` for the aborted frame; the subsequent frame 8'h55 is received.
- `BYTE_RX_PARITY_EN` build:
  - Send 8'h03 with parity bit 1 → `parity_err` pulse, no `en`.
  - Send 8'h03 with parity bit 0 → `en` at t0+171 with `data`=8'h03.
